// File: rtl/pearray_tiled.sv
// Tiled matrix-vector engine: y = M*x over NUM_PE MAC lanes, zero-skipping x, one shared BRAM port.
// BRAM reads return two cycles after issue; vector loaded once per job, rows processed tile by tile.
module pearray_tiled #(
    parameter int H_SIZE = 6,
    parameter int NUM_PE = 8,
    parameter int ROW_W  = 8
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              start,
    input  logic [H_SIZE:0]   vec_len,
    input  logic [ROW_W:0]    num_rows,
    input  logic [31:0]       vec_base,
    input  logic [31:0]       mat_base,
    input  logic [31:0]       res_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       calc_cycles,
    output logic [31:0]       BRAM_ADDR,
    output logic [31:0]       BRAM_WRDATA,
    output logic [3:0]        BRAM_WE,
    output logic              BRAM_CLK,
    input  logic [31:0]       BRAM_RDDATA
);

    localparam int DEPTH = 1 << H_SIZE;
    localparam int LW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_INIT, S_LOAD, S_CALC, S_HARV, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [H_SIZE:0]     vl_q, vl_d;
    logic [ROW_W:0]      nr_q, nr_d;
    logic [ROW_W:0]      rows_left_q, rows_left_d;
    logic [31:0]         vec_ptr_q, vec_ptr_d;
    logic [31:0]         mat_ptr_q, mat_ptr_d;
    logic [31:0]         res_ptr_q, res_ptr_d;
    logic [H_SIZE-1:0]   k_q, k_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                iss_done_q, iss_done_d;
    logic                err_q, err_d;
    logic [31:0]         calc_cycles_q, calc_cycles_d;

    // Read-return tags: where the word arriving two cycles later must land.
    logic                st1_vld_q, st1_vld_d, st2_vld_q, st2_vld_d;
    logic                st1_vec_q, st1_vec_d, st2_vec_q, st2_vec_d;
    logic [H_SIZE-1:0]   st1_k_q, st1_k_d, st2_k_q, st2_k_d;
    logic [LW-1:0]       st1_lane_q, st1_lane_d, st2_lane_q, st2_lane_d;

    logic [DEPTH-1:0]    pend_q, pend_d;
    logic                m1_vld_q, m1_vld_d, m2_vld_q, m2_vld_d;
    logic [31:0]         m1_x_q, m1_x_d;
    logic [H_SIZE-1:0]   m1_k_q, m1_k_d;
    logic [31:0]         prod_q [NUM_PE];
    logic [31:0]         prod_d [NUM_PE];
    logic [31:0]         acc_q  [NUM_PE];
    logic [31:0]         acc_d  [NUM_PE];

    logic [31:0]         gram_mem [DEPTH];
    logic [DEPTH-1:0]    zero_map;
    logic [31:0]         lane_mem [NUM_PE][DEPTH];

    logic                rd_en;
    logic [31:0]         rd_addr;
    logic [31:0]         active;
    logic                last_k, last_lane, illegal;
    logic [H_SIZE-1:0]   sel;
    logic                sel_found;
    logic [DEPTH-1:0]    vmask;

    assign BRAM_CLK    = ~S_AXI_ACLK;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign calc_cycles = calc_cycles_q;

    assign active    = (32'(rows_left_q) > 32'(NUM_PE)) ? 32'(NUM_PE) : 32'(rows_left_q);
    assign last_k    = ({1'b0, k_q} == (vl_q - 1'b1));
    assign last_lane = (32'(lane_q) == (active - 32'd1));
    assign illegal   = (vl_q == '0) || (32'(vl_q) > 32'(DEPTH)) ||
                       (nr_q == '0) || (32'(nr_q) > (32'd1 << ROW_W));

    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel       = H_SIZE'(i);
                sel_found = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            vmask[i] = (32'(i) < 32'(vl_q));
        end
    end

    always_comb begin
        BRAM_ADDR   = '0;
        BRAM_WRDATA = '0;
        BRAM_WE     = '0;
        if (rd_en) begin
            BRAM_ADDR = {rd_addr[29:0], 2'b00};
        end
        if (state_q == S_HARV) begin
            BRAM_ADDR   = {res_ptr_q[29:0], 2'b00};
            BRAM_WRDATA = acc_q[lane_q];
            BRAM_WE     = 4'b1111;
        end
    end

    always_comb begin
        state_d       = state_q;
        vl_d          = vl_q;
        nr_d          = nr_q;
        rows_left_d   = rows_left_q;
        vec_ptr_d     = vec_ptr_q;
        mat_ptr_d     = mat_ptr_q;
        res_ptr_d     = res_ptr_q;
        k_d           = k_q;
        lane_d        = lane_q;
        iss_done_d    = iss_done_q;
        err_d         = err_q;
        calc_cycles_d = calc_cycles_q;
        pend_d        = pend_q;
        rd_en         = 1'b0;
        rd_addr       = '0;

        st1_vld_d  = 1'b0;
        st1_vec_d  = 1'b0;
        st1_k_d    = k_q;
        st1_lane_d = lane_q;
        st2_vld_d  = st1_vld_q;
        st2_vec_d  = st1_vec_q;
        st2_k_d    = st1_k_q;
        st2_lane_d = st1_lane_q;

        m1_vld_d = 1'b0;
        m1_x_d   = m1_x_q;
        m1_k_d   = m1_k_q;
        m2_vld_d = m1_vld_q;
        // Low 32 bits of a signed product equal those of the unsigned product.
        for (int p = 0; p < NUM_PE; p++) begin
            prod_d[p] = m1_vld_q ? (m1_x_q * lane_mem[p][m1_k_q]) : prod_q[p];
            acc_d[p]  = acc_q[p];
            if (m2_vld_q && (32'(p) < active)) begin
                acc_d[p] = acc_q[p] + prod_q[p];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vl_d          = vec_len;
                    nr_d          = num_rows;
                    rows_left_d   = num_rows;
                    vec_ptr_d     = vec_base;
                    mat_ptr_d     = mat_base;
                    res_ptr_d     = res_base;
                    err_d         = 1'b0;
                    calc_cycles_d = '0;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                k_d        = '0;
                lane_d     = '0;
                iss_done_d = 1'b0;
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (!iss_done_q) begin
                    rd_en     = 1'b1;
                    rd_addr   = vec_ptr_q;
                    vec_ptr_d = vec_ptr_q + 32'd1;
                    st1_vld_d = 1'b1;
                    st1_vec_d = 1'b1;
                    if (last_k) begin
                        k_d        = '0;
                        iss_done_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (!st1_vld_q) begin
                    lane_d     = '0;
                    iss_done_d = 1'b0;
                    for (int p = 0; p < NUM_PE; p++) acc_d[p] = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!iss_done_q) begin
                    rd_en     = 1'b1;
                    rd_addr   = mat_ptr_q;
                    mat_ptr_d = mat_ptr_q + 32'd1;
                    st1_vld_d = 1'b1;
                    if (last_k) begin
                        k_d = '0;
                        if (last_lane) iss_done_d = 1'b1;
                        else           lane_d     = lane_q + 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (!st1_vld_q) begin
                    pend_d  = vmask & ~zero_map;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                calc_cycles_d = calc_cycles_q + 32'd1;
                if (sel_found) begin
                    m1_vld_d    = 1'b1;
                    m1_x_d      = gram_mem[sel];
                    m1_k_d      = sel;
                    pend_d[sel] = 1'b0;
                end else if (!m1_vld_q) begin
                    // The final product lands in acc on this same edge.
                    lane_d  = '0;
                    state_d = S_HARV;
                end
            end
            S_HARV: begin
                res_ptr_d = res_ptr_q + 32'd1;
                if (last_lane) begin
                    lane_d = '0;
                    if (32'(rows_left_q) > 32'(NUM_PE)) begin
                        rows_left_d = rows_left_q - (ROW_W + 1)'(NUM_PE);
                        k_d         = '0;
                        iss_done_d  = 1'b0;
                        for (int p = 0; p < NUM_PE; p++) acc_d[p] = '0;
                        state_d     = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q       <= S_IDLE;
            vl_q          <= '0;
            nr_q          <= '0;
            rows_left_q   <= '0;
            vec_ptr_q     <= '0;
            mat_ptr_q     <= '0;
            res_ptr_q     <= '0;
            k_q           <= '0;
            lane_q        <= '0;
            iss_done_q    <= 1'b0;
            err_q         <= 1'b0;
            calc_cycles_q <= '0;
            st1_vld_q     <= 1'b0;
            st1_vec_q     <= 1'b0;
            st1_k_q       <= '0;
            st1_lane_q    <= '0;
            st2_vld_q     <= 1'b0;
            st2_vec_q     <= 1'b0;
            st2_k_q       <= '0;
            st2_lane_q    <= '0;
            pend_q        <= '0;
            m1_vld_q      <= 1'b0;
            m1_x_q        <= '0;
            m1_k_q        <= '0;
            m2_vld_q      <= 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                prod_q[p] <= '0;
                acc_q[p]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            vl_q          <= vl_d;
            nr_q          <= nr_d;
            rows_left_q   <= rows_left_d;
            vec_ptr_q     <= vec_ptr_d;
            mat_ptr_q     <= mat_ptr_d;
            res_ptr_q     <= res_ptr_d;
            k_q           <= k_d;
            lane_q        <= lane_d;
            iss_done_q    <= iss_done_d;
            err_q         <= err_d;
            calc_cycles_q <= calc_cycles_d;
            st1_vld_q     <= st1_vld_d;
            st1_vec_q     <= st1_vec_d;
            st1_k_q       <= st1_k_d;
            st1_lane_q    <= st1_lane_d;
            st2_vld_q     <= st2_vld_d;
            st2_vec_q     <= st2_vec_d;
            st2_k_q       <= st2_k_d;
            st2_lane_q    <= st2_lane_d;
            pend_q        <= pend_d;
            m1_vld_q      <= m1_vld_d;
            m1_x_q        <= m1_x_d;
            m1_k_q        <= m1_k_d;
            m2_vld_q      <= m2_vld_d;
            for (int p = 0; p < NUM_PE; p++) begin
                prod_q[p] <= prod_d[p];
                acc_q[p]  <= acc_d[p];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (st2_vld_q) begin
            if (st2_vec_q) begin
                gram_mem[st2_k_q] <= BRAM_RDDATA;
                zero_map[st2_k_q] <= (BRAM_RDDATA == 32'd0);
            end else begin
                lane_mem[st2_lane_q][st2_k_q] <= BRAM_RDDATA;
            end
        end
    end

endmodule
